cordic_vectoring: RTL and testbench
===================================

# cordic_vectoring

Iterative CORDIC engine in vectoring mode: it takes a signed Cartesian pair (x, y) and returns atan2(y, x) and the gain-compensated magnitude sqrt(x²+y²). It is the inverse companion of the rotation-mode sine/cosine generator. Typical uses are recovering phase and amplitude from I/Q samples and closing angle loops in the same fixed-point domain. One request is processed at a time under a start/busy/done handshake.

## Interface
- ITER, 14, number of micro-rotations; legal range 1..14 (the atan table is zero beyond index 13).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- x_in  in  16  signed two's-complement X component.
- y_in  in  16  signed two's-complement Y component.
- busy  out  1  high while a request is in flight.
- done  out  1  one-cycle pulse marking valid angle/magnitude.
- angle  out  16  signed Q3.13 radians, range [-π, +π]; π = 25736 (0x6488).
- magnitude  out  16  unsigned magnitude in x_in/y_in units; saturates at 0xFFFF.

## Operation
- States: IDLE, ITER, SCALE.
- **IDLE.** When start=1, capture the inputs into 18-bit signed working registers X and Y (2 guard bits), plus an 16-bit angle accumulator Z. Apply quadrant pre-rotation at capture:
  - x_in ≥ 0: X=x_in, Y=y_in, Z=0.
  - x_in < 0 and y_in ≥ 0: X=y_in, Y=−x_in, Z=+12868 (π/2).
  - x_in < 0 and y_in < 0: X=−y_in, Y=x_in, Z=−12868.
  - Then set counter i=0, busy=1 and go to ITER.
- **ITER** (one micro-rotation per cycle):
  - If Y ≥ 0: X += Y>>>i, Y −= X>>>i, Z += ATAN[i].
  - Else: X −= Y>>>i, Y += X>>>i, Z −= ATAN[i].
  - All three updates use the previous-cycle values and arithmetic shifts.
  - When i = ITER−1, go to SCALE; otherwise i++.
- **SCALE.**
  - magnitude = (X × 39797) >> 16, i.e. 1/K ≈ 0.60725 in Q0.16, truncated and saturated to 0xFFFF.
  - angle = Z.
  - done=1, busy=0, go to IDLE.
- Zero input: x_in = y_in = 0 forces angle=0 and magnitude=0 at SCALE, with normal latency.
- x_in = −32768 and/or y_in = −32768 must not overflow; the 18-bit internal width covers K·√2·32768.
- Outputs angle and magnitude hold their last result until the next SCALE.

## Timing
- Reset values: busy=0, done=0, angle=0, magnitude=0, state IDLE, X/Y/Z/i cleared.
- Start sampled at edge E0. Iterations occur at edges E1..E_ITER. SCALE occurs at edge E_ITER+1.
- done is high for exactly the cycle following E_ITER+1. Latency is ITER+1 cycles (15 by default).
- busy is high from the cycle after E0 through the cycle before done; busy and done are never high together.
- start while busy is ignored, with no queueing.
- start during the done cycle is accepted, since the state is IDLE; done and the new busy then overlap by zero cycles. Back-to-back throughput is one result per ITER+2 cycles.
- rst mid-operation aborts immediately: outputs return to their reset values and no done is emitted.
- Inputs need only be valid in the start cycle.

## Structure
- Package cordic_pkg holds:
  - ATAN table, Q3.13: 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1.
  - Constants HALF_PI=12868, PI=25736, INV_K=39797.
  - Widths DATA_W=16 and WORK_W=18.
  - State enum.
  - The rotation-mode block shares this package.
- One sub-module: cordic_vec_stage, combinational. It takes X, Y, Z, i and returns the next X, Y, Z. Keep the FSM, counter and scaling in the top.

## Test plan
- (x_in=16384, y_in=0) → angle 0 ±3 LSB, magnitude 16384 ±4, done exactly 15 cycles after start.
- (0, 16384) → angle 12868 ±3; (−16384, −16384) → angle −19302 ±3, magnitude 23170 ±4.
- (−32768, 0) → angle ≈ ±25736 ±3 (either sign accepted at ±π), magnitude 32768 ±4, no wrap; (0, 0) → angle 0, magnitude 0.
- start pulsed during busy (cycles 3 and 10) → single done, results match the first request only.
- rst asserted at cycle 7 of a request → busy/done/angle/magnitude go 0 asynchronously; a subsequent request completes normally in 15 cycles.
- 1000 random (x, y) pairs back-to-back, including start in the done cycle → every result within tolerance of a double-precision atan2/hypot model; one done per accepted start.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, atan table and state encoding for the CORDIC engines
package cordic_pkg;
   localparam int DATA_W = 16;
   localparam int WORK_W = 18;
   localparam logic signed [DATA_W-1:0] HALF_PI = 16'sd12868;
   localparam logic signed [DATA_W-1:0] PI = 16'sd25736;
   localparam logic [DATA_W-1:0] INV_K = 16'd39797;
   typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE} state_t;
   function automatic logic signed [DATA_W-1:0] atan_lut(input logic [3:0] i);
      case (i)
         4'd0:  return 16'sd6434;
         4'd1:  return 16'sd3798;
         4'd2:  return 16'sd2007;
         4'd3:  return 16'sd1019;
         4'd4:  return 16'sd511;
         4'd5:  return 16'sd256;
         4'd6:  return 16'sd128;
         4'd7:  return 16'sd64;
         4'd8:  return 16'sd32;
         4'd9:  return 16'sd16;
         4'd10: return 16'sd8;
         4'd11: return 16'sd4;
         4'd12: return 16'sd2;
         4'd13: return 16'sd1;
         default: return 16'sd0;
      endcase
   endfunction
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one vectoring micro-rotation, driving Y toward zero
module cordic_vec_stage
   import cordic_pkg::*;
(
   input  logic signed [WORK_W-1:0] i_x,
   input  logic signed [WORK_W-1:0] i_y,
   input  logic signed [DATA_W-1:0] i_z,
   input  logic [3:0]               i_idx,
   output logic signed [WORK_W-1:0] o_x,
   output logic signed [WORK_W-1:0] o_y,
   output logic signed [DATA_W-1:0] o_z
);
   logic                     w_neg;
   logic signed [WORK_W-1:0] w_xs, w_ys;
   logic signed [DATA_W-1:0] w_atan;
   assign w_neg  = i_y[WORK_W-1];
   assign w_xs   = i_x >>> i_idx;
   assign w_ys   = i_y >>> i_idx;
   assign w_atan = atan_lut(i_idx);
   assign o_x = w_neg ? i_x - w_ys : i_x + w_ys;
   assign o_y = w_neg ? i_y + w_xs : i_y - w_xs;
   assign o_z = w_neg ? i_z - w_atan : i_z + w_atan;
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC returning atan2(y, x) and gain-compensated magnitude
module cordic_vectoring
   import cordic_pkg::*;
#(
   parameter int ITER = 14
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] y_in,
   output logic                     busy,
   output logic                     done,
   output logic signed [DATA_W-1:0] angle,
   output logic [DATA_W-1:0]        magnitude
);
   state_t                   r_state, w_next;
   logic signed [WORK_W-1:0] r_x, r_y, w_x, w_y, w_xe, w_ye, w_x0, w_y0;
   logic signed [DATA_W-1:0] r_z, w_z, w_z0, r_angle;
   logic [DATA_W-1:0]        r_mag, w_mag;
   logic [3:0]               r_i;
   logic                     r_zero, r_done, w_take;
   logic signed [34:0]       w_prod;
   logic signed [18:0]       w_sc;

   assign w_take = (r_state == S_IDLE) && start;
   assign w_xe = {{(WORK_W-DATA_W){x_in[DATA_W-1]}}, x_in};
   assign w_ye = {{(WORK_W-DATA_W){y_in[DATA_W-1]}}, y_in};
   // Left half-plane inputs are turned by -/+90 degrees so the iterations only span +/-99 degrees
   assign w_x0 = !x_in[DATA_W-1] ? w_xe : (!y_in[DATA_W-1] ? w_ye : -w_ye);
   assign w_y0 = !x_in[DATA_W-1] ? w_ye : (!y_in[DATA_W-1] ? -w_xe : w_xe);
   assign w_z0 = !x_in[DATA_W-1] ? 16'sd0 : (!y_in[DATA_W-1] ? HALF_PI : -HALF_PI);

   assign w_prod = r_x * $signed({1'b0, INV_K});
   assign w_sc   = 19'(w_prod >>> 16);
   assign w_mag  = w_sc[18] ? '0 : (|w_sc[17:16] ? 16'hFFFF : w_sc[15:0]);

   cordic_vec_stage u_stage (
      .i_x(r_x), .i_y(r_y), .i_z(r_z), .i_idx(r_i),
      .o_x(w_x), .o_y(w_y), .o_z(w_z)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_take) w_next = S_ITER;
      else if (r_state == S_ITER && r_i == 4'(ITER-1)) w_next = S_SCALE;
      else if (r_state == S_SCALE) w_next = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x <= '0;
         r_y <= '0;
         r_z <= '0;
         r_i <= '0;
         r_zero <= 1'b0;
         r_done <= 1'b0;
         r_angle <= '0;
         r_mag <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_take) begin
            r_x <= w_x0;
            r_y <= w_y0;
            r_z <= w_z0;
            r_i <= '0;
            r_zero <= (x_in == 16'sd0) && (y_in == 16'sd0);
         end
         if (r_state == S_ITER) begin
            r_x <= w_x;
            r_y <= w_y;
            r_z <= w_z;
            r_i <= r_i + 4'd1;
         end
         if (r_state == S_SCALE) begin
            r_angle <= r_zero ? '0 : r_z;
            r_mag <= r_zero ? '0 : w_mag;
            r_done <= 1'b1;
         end
      end
   end

   assign busy = r_state != S_IDLE;
   assign done = r_done;
   assign angle = r_angle;
   assign magnitude = r_mag;
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: directed table, handshake corner cases and random atan2/hypot comparison
module tb_cordic_vectoring;
   localparam real Q = 8192.0;
   localparam real TWO_PI_Q = 2.0 * 3.14159265358979 * 8192.0;

   logic clk = 1'b0;
   logic rst, start, busy, done;
   logic signed [15:0] x_in, y_in, angle;
   logic [15:0] magnitude;
   int tests = 0;
   int fails = 0;

   typedef struct {
      int  x;
      int  y;
      real ea;
      real em;
      real ta;
      real tm;
   } vec_t;
   vec_t vecs[6];

   cordic_vectoring dut (
      .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
      .busy(busy), .done(done), .angle(angle), .magnitude(magnitude)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy && done) begin
         fails++;
         $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
      end
   end

   function automatic real wrap(input real d);
      real r = d;
      while (r > TWO_PI_Q / 2.0) r -= TWO_PI_Q;
      while (r < -TWO_PI_Q / 2.0) r += TWO_PI_Q;
      return r;
   endfunction

   function automatic void model(input int x, input int y, output real a, output real m);
      if (x == 0 && y == 0) begin
         a = 0.0;
         m = 0.0;
      end else begin
         a = $atan2(real'(y), real'(x)) * Q;
         m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
         if (m > 65535.0) m = 65535.0;
      end
   endfunction

   task automatic check_int(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic check_ang(input string name, input real act, input real exp, input real tol);
      real d = wrap(act - exp);
      tests++;
      if (d > tol || d < -tol) begin
         fails++;
         $display("FAIL %s: angle got %0.1f, required %0.1f +/- %0.1f", name, act, exp, tol);
      end
   endtask

   task automatic check_mag(input string name, input real act, input real exp, input real tol);
      tests++;
      if (act - exp > tol || exp - act > tol) begin
         fails++;
         $display("FAIL %s: magnitude got %0.1f, required %0.1f +/- %0.1f", name, act, exp, tol);
      end
   endtask

   task automatic go(input int x, input int y);
      @(negedge clk);
      x_in = 16'(x);
      y_in = 16'(y);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
   endtask

   initial begin
      int n, dones, lat, x, y, nx, ny;
      real ea, em, a_cap, m_cap;
      vecs[0] = '{16384, 0, 0.0, 16384.0, 3.0, 4.0};
      vecs[1] = '{0, 16384, 12868.0, 16384.0, 3.0, 4.0};
      vecs[2] = '{-16384, -16384, -19302.0, 23170.0, 3.0, 4.0};
      vecs[3] = '{-32768, 0, 25736.0, 32768.0, 3.0, 4.0};
      vecs[4] = '{0, 0, 0.0, 0.0, 0.0, 0.0};
      vecs[5] = '{16384, -16384, -6434.0, 23170.0, 3.0, 4.0};
      rst = 1'b1;
      start = 1'b0;
      x_in = '0;
      y_in = '0;
      repeat (2) @(posedge clk);
      #1;
      check_int("reset_busy", int'(busy), 0);
      check_int("reset_done", int'(done), 0);
      check_int("reset_angle", int'(angle), 0);
      check_int("reset_mag", int'(magnitude), 0);
      @(negedge clk) rst = 1'b0;

      foreach (vecs[i]) begin
         go(vecs[i].x, vecs[i].y);
         wait_done(n);
         check_int($sformatf("vec%0d_latency", i), n, 15);
         check_ang($sformatf("vec%0d", i), real'(angle), vecs[i].ea, vecs[i].ta);
         check_mag($sformatf("vec%0d", i), real'(magnitude), vecs[i].em, vecs[i].tm);
      end

      // start pulses while busy must be ignored
      go(4000, 3000);
      dones = 0;
      lat = 0;
      a_cap = 0.0;
      m_cap = 0.0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 3 || c == 10) begin
            start = 1'b1;
            x_in = -16'sd5000;
            y_in = -16'sd7000;
         end
         @(posedge clk);
         #1 start = 1'b0;
         if (done) begin
            dones++;
            lat = c;
            a_cap = real'(angle);
            m_cap = real'(magnitude);
         end
      end
      model(4000, 3000, ea, em);
      check_int("busy_start_dones", dones, 1);
      check_int("busy_start_latency", lat, 15);
      check_ang("busy_start", a_cap, ea, 3.0);
      check_mag("busy_start", m_cap, em, 4.0);

      // asynchronous abort mid-request
      go(-3000, 8000);
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_int("abort_busy", int'(busy), 0);
      check_int("abort_done", int'(done), 0);
      check_int("abort_angle", int'(angle), 0);
      check_int("abort_mag", int'(magnitude), 0);
      @(negedge clk) rst = 1'b0;
      dones = 0;
      repeat (20) begin
         @(posedge clk);
         #1 if (done) dones++;
      end
      check_int("abort_no_done", dones, 0);
      go(-3000, 8000);
      wait_done(n);
      model(-3000, 8000, ea, em);
      check_int("after_abort_latency", n, 15);
      check_ang("after_abort", real'(angle), ea, 3.0);
      check_mag("after_abort", real'(magnitude), em, 4.0);

      // random back-to-back, next start issued in each done cycle
      x = 0;
      y = 0;
      go(x, y);
      for (int k = 0; k < 1000; k++) begin
         wait_done(n);
         model(x, y, ea, em);
         check_int($sformatf("rand%0d_latency", k), n, 15);
         check_ang($sformatf("rand%0d (%0d,%0d)", k, x, y), real'(angle), ea,
                   (em < 1.0) ? 0.0 : 4.0 + 40960.0 / em);
         check_mag($sformatf("rand%0d (%0d,%0d)", k, x, y), real'(magnitude), em, 6.0);
         if (n >= 40) break;
         if (k % 100 == 7) begin
            nx = -32768;
            ny = (k % 200 == 7) ? -32768 : 32767;
         end else begin
            nx = int'($urandom_range(0, 65535)) - 32768;
            ny = int'($urandom_range(0, 65535)) - 32768;
         end
         x = nx;
         y = ny;
         if (k < 999) begin
            x_in = 16'(x);
            y_in = 16'(y);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
